mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus (rd, wr, 13-bit addr, 8-bit data) between two requesters.
- Requester 0 is the CPU core's fetch/execute bus; requester 1 is a program loader/DMA port.
- Arbitrates round-robin, sequences each transfer with a programmable wait-state count, and returns read data plus a one-cycle acknowledge.
- Sits between the CPU core and the top-level tristate data driver.

Parameters:
- AW, 13, address width
- DW, 8, data width
- WAIT_STATES, 1, extra cycles rd/wr is held beyond the first access cycle (range 0..15)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-low reset
- m0_req  in  1  CPU requests a transfer; held until m0_ack
- m0_wr  in  1  1 = write, 0 = read; stable while m0_req
- m0_addr  in  AW  transfer address; stable while m0_req
- m0_wdata  in  DW  write data
- m0_ack  out  1  one-cycle transfer-complete pulse
- m0_rdata  out  DW  read data, valid in m0_ack cycle, held until next m0 read
- m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0, for requester 1
- rd  out  1  bus read strobe
- wr  out  1  bus write strobe
- addr  out  AW  bus address
- bus_wdata  out  DW  value for the top-level tristate driver
- bus_oe  out  1  drive enable for the tristate, equals wr
- bus_rdata  in  DW  sampled bus data
- gnt  out  2  one-hot current owner, 00 when idle
- busy  out  1  high in ACCESS and DONE

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-low.
- Reset values: all outputs 0, rdata registers 0, FSM = IDLE, last-served pointer = 1, so m0 wins the first tie.
- Synchronous reset mid-transfer: FSM returns to IDLE in the next cycle, rd/wr drop, no ack is issued, and the requester must re-request.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if exactly one req is high, grant it. If both are high, grant the requester not last served. Register that owner's addr/wr/wdata into the bus outputs, set gnt, load the wait counter with WAIT_STATES, and go to ACCESS. With no req, stay in IDLE.
- ACCESS: rd = ~owner_wr, wr = owner_wr, bus_oe = wr. The counter decrements each cycle. When the counter is 0: capture bus_rdata into owner rdata (reads only) and go to DONE. ACCESS lasts WAIT_STATES+1 cycles.
- DONE: rd/wr/bus_oe = 0, addr held, owner ack = 1 for exactly one cycle, update last-served = owner, gnt cleared next cycle, return to IDLE.
- Latency: req first sampled high in IDLE at cycle N gives strobe in cycles N+1..N+1+WAIT_STATES and ack at N+2+WAIT_STATES. Minimum back-to-back period is WAIT_STATES+3 cycles.
- A req still high in the cycle after its ack is treated as a new request.
- Inputs that change while a transfer is in flight are ignored, because the bus outputs were registered at grant.
- The non-owner's req is never dropped; it is served at the next IDLE.
- Two acks never occur in the same cycle, and rd and wr are never both high.
- WAIT_STATES=0: single-cycle ACCESS.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- Defined:
  - Adds inputs m0_lock and m1_lock.
  - If the owner has lock high in its DONE cycle, and it requests in the following IDLE, it is granted again regardless of round-robin, for atomic multi-byte sequences.
  - The other requester waits; lock with req low is ignored.
  - last-served is still updated.
- Undefined: lock ports are absent and arbitration is pure round-robin.

Decomposition:
- Shared package mem_bus_pkg:
  - FSM state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2)
  - AW/DW defaults
  - requester index constants M0=0, M1=1
- One natural sub-module: rr_arb2, the two-way round-robin grant logic with last-served pointer and optional lock override.
- FSM, wait counter and datapath registers stay in mem_bus_arbiter.

Test Plan:
- Reset, then m0 read: WAIT_STATES=1, m0_req=1, m0_wr=0, m0_addr=13'h0A5 at cycle 0, bus_rdata=8'h3C. Required: rd=1 and addr=0A5 in cycles 1-2, m0_ack=1 and m0_rdata=3C in cycle 3, gnt=01 in cycles 1-3.
- m1 write: m1_addr=13'h1FFF, m1_wdata=8'hE7. Required: wr=bus_oe=1 and bus_wdata=E7 for 2 cycles, m1_ack pulses, rd stays 0, m1_rdata unchanged.
- Simultaneous requests held continuously: grants go m0, m1, m0, m1. Each ack is a single cycle, periods are 4 cycles apart, and no cycle has two acks.
- Reset asserted in the second ACCESS cycle of an m0 read: next cycle rd=0, gnt=00, no m0_ack, m0_rdata=00. After release with req held, the transfer restarts from IDLE.
- WAIT_STATES=0 and WAIT_STATES=15: strobe width is 1 and 16 cycles respectively, with ack exactly one cycle after the strobe ends.
- MEM_ARB_LOCK_EN: m0 has lock=1 on two transfers while m1_req is high. Required: m0 is served twice back-to-back, then m1. With the macro undefined, the same stimulus alternates m0, m1.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the external memory bus arbiter.
package mem_bus_pkg;

   localparam int AW_DEF = 13;
   localparam int DW_DEF = 8;
   localparam int M0     = 0;
   localparam int M1     = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester handshakes and external bus signals of mem_bus_arbiter.
// MEM_ARB_LOCK_EN adds the per-requester lock inputs.
interface mem_bus_arbiter_if #(
   parameter int AW = mem_bus_pkg::AW_DEF,
   parameter int DW = mem_bus_pkg::DW_DEF
);
   logic          m0_req, m0_wr, m0_ack;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata, m0_rdata;
   logic          m1_req, m1_wr, m1_ack;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata, m1_rdata;
   logic          rd, wr, bus_oe, busy;
   logic [AW-1:0] addr;
   logic [DW-1:0] bus_wdata, bus_rdata;
   logic [1:0]    gnt;
`ifdef MEM_ARB_LOCK_EN
   logic          m0_lock, m1_lock;
`endif

   // Requester / board side.
   modport master (
`ifdef MEM_ARB_LOCK_EN
      output m0_lock, m1_lock,
`endif
      output m0_req, m0_wr, m0_addr, m0_wdata,
      output m1_req, m1_wr, m1_addr, m1_wdata, bus_rdata,
      input  m0_ack, m0_rdata, m1_ack, m1_rdata,
      input  rd, wr, addr, bus_wdata, bus_oe, gnt, busy
   );

   // Arbiter side.
   modport slave (
`ifdef MEM_ARB_LOCK_EN
      input  m0_lock, m1_lock,
`endif
      input  m0_req, m0_wr, m0_addr, m0_wdata,
      input  m1_req, m1_wr, m1_addr, m1_wdata, bus_rdata,
      output m0_ack, m0_rdata, m1_ack, m1_rdata,
      output rd, wr, addr, bus_wdata, bus_oe, gnt, busy
   );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with last-served pointer (resets to 1 so M0 wins the first tie).
// MEM_ARB_LOCK_EN adds a lock override that re-grants the previous owner.
module rr_arb2
   import mem_bus_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       upd_i,
   input  logic       owner_i,
`ifdef MEM_ARB_LOCK_EN
   input  logic       take_i,
   input  logic       lock_i,
`endif
   output logic [1:0] gnt_o
);

   logic last_q;

   always_ff @(posedge clk) begin
      if (!rst)       last_q <= 1'b1;
      else if (upd_i) last_q <= owner_i;
   end

`ifdef MEM_ARB_LOCK_EN
   logic lock_q, lock_own_q;

   // Lock is armed in the owner's DONE cycle and consumed by the next grant.
   always_ff @(posedge clk) begin
      if (!rst) begin
         lock_q     <= 1'b0;
         lock_own_q <= 1'b0;
      end else if (upd_i) begin
         lock_q     <= lock_i;
         lock_own_q <= owner_i;
      end else if (take_i) begin
         lock_q     <= 1'b0;
      end
   end
`endif

   always_comb begin
      gnt_o = 2'b00;
      if (req_i == 2'b11)  gnt_o = onehot2(~last_q);
      else if (req_i[M0])  gnt_o = onehot2(1'b0);
      else if (req_i[M1])  gnt_o = onehot2(1'b1);
`ifdef MEM_ARB_LOCK_EN
      if (lock_q && req_i[lock_own_q]) gnt_o = onehot2(lock_own_q);
`endif
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester external memory bus arbiter: round-robin grant, WAIT_STATES-stretched strobe,
// one-cycle ack with captured read data. Define MEM_ARB_LOCK_EN for atomic lock re-grant.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int AW          = AW_DEF,
   parameter int DW          = DW_DEF,
   parameter int WAIT_STATES = 1
) (
   input logic              clk,
   input logic              rst,
   mem_bus_arbiter_if.slave bus
);

   state_e        state_q;
   logic [3:0]    cnt_q;
   logic          owner_q;
   logic          rd_q, wr_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q, rdata0_q, rdata1_q;
   logic [1:0]    gnt_q;
   logic          ack0_q, ack1_q;

   logic [1:0]    req, arb_gnt;
   logic          take, upd;

   assign req  = {bus.m1_req, bus.m0_req};
   assign take = (state_q == ST_IDLE) && (arb_gnt != 2'b00);
   assign upd  = (state_q == ST_DONE);

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req_i   (req),
      .upd_i   (upd),
      .owner_i (owner_q),
`ifdef MEM_ARB_LOCK_EN
      .take_i  (take),
      .lock_i  (owner_q ? bus.m1_lock : bus.m0_lock),
`endif
      .gnt_o   (arb_gnt)
   );

   // Bus outputs are loaded at grant so requester changes mid-transfer are ignored.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         owner_q  <= 1'b0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         gnt_q    <= '0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (take) begin
               owner_q <= arb_gnt[M1];
               gnt_q   <= arb_gnt;
               cnt_q   <= 4'(WAIT_STATES);
               state_q <= ST_ACCESS;
               if (arb_gnt[M1]) begin
                  rd_q    <= ~bus.m1_wr;
                  wr_q    <= bus.m1_wr;
                  addr_q  <= bus.m1_addr;
                  wdata_q <= bus.m1_wdata;
               end else begin
                  rd_q    <= ~bus.m0_wr;
                  wr_q    <= bus.m0_wr;
                  addr_q  <= bus.m0_addr;
                  wdata_q <= bus.m0_wdata;
               end
            end
            ST_ACCESS: if (cnt_q == 4'd0) begin
               rd_q    <= 1'b0;
               wr_q    <= 1'b0;
               if (!wr_q) begin
                  if (owner_q) rdata1_q <= bus.bus_rdata;
                  else         rdata0_q <= bus.bus_rdata;
               end
               ack0_q  <= ~owner_q;
               ack1_q  <= owner_q;
               state_q <= ST_DONE;
            end else begin
               cnt_q   <= cnt_q - 4'd1;
            end
            ST_DONE: begin
               gnt_q   <= 2'b00;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.rd        = rd_q;
   assign bus.wr        = wr_q;
   assign bus.bus_oe    = wr_q;
   assign bus.addr      = addr_q;
   assign bus.bus_wdata = wdata_q;
   assign bus.gnt       = gnt_q;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.m0_ack    = ack0_q;
   assign bus.m1_ack    = ack1_q;
   assign bus.m0_rdata  = rdata0_q;
   assign bus.m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with one instance per WAIT_STATES value (1, 0, 15);
// only the selected instance sees requests.
module tb_mem_bus_arbiter;
   import mem_bus_pkg::*;

   typedef struct {
      logic        who;
      logic        wr;
      logic [12:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  rdata;
      int          gap;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0, bad = 0;
   logic        clk = 1'b0, rst = 1'b0;
   int          sel = 0;
   logic        m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
   logic [12:0] m0_addr = '0, m1_addr = '0;
   logic [7:0]  m0_wdata = '0, m1_wdata = '0, bus_rdata = '0;
`ifdef MEM_ARB_LOCK_EN
   logic        m0_lock = 1'b0, m1_lock = 1'b0;
`endif

   logic        rd_a[3], wr_a[3], oe_a[3], busy_a[3], ack0_a[3], ack1_a[3];
   logic [12:0] addr_a[3];
   logic [7:0]  bwd_a[3], rd0_a[3], rd1_a[3];
   logic [1:0]  gnt_a[3];
   logic [7:0]  rmod[3][2];
   bit          done = 1'b0, fin = 1'b0;
   bit          rst_d = 1'b1;

   always #5 clk = ~clk;
   always @(posedge clk) rst_d <= rst;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int WS = (k == 0) ? 1 : (k == 1) ? 0 : 15;
      mem_bus_arbiter_if #(.AW(13), .DW(8)) bif ();
      assign bif.m0_req    = m0_req && (sel == k);
      assign bif.m0_wr     = m0_wr;
      assign bif.m0_addr   = m0_addr;
      assign bif.m0_wdata  = m0_wdata;
      assign bif.m1_req    = m1_req && (sel == k);
      assign bif.m1_wr     = m1_wr;
      assign bif.m1_addr   = m1_addr;
      assign bif.m1_wdata  = m1_wdata;
      assign bif.bus_rdata = bus_rdata;
`ifdef MEM_ARB_LOCK_EN
      assign bif.m0_lock   = m0_lock;
      assign bif.m1_lock   = m1_lock;
`endif
      mem_bus_arbiter #(.AW(13), .DW(8), .WAIT_STATES(WS)) dut (
         .clk (clk),
         .rst (rst),
         .bus (bif)
      );
      assign rd_a[k]   = bif.rd;
      assign wr_a[k]   = bif.wr;
      assign oe_a[k]   = bif.bus_oe;
      assign busy_a[k] = bif.busy;
      assign ack0_a[k] = bif.m0_ack;
      assign ack1_a[k] = bif.m1_ack;
      assign addr_a[k] = bif.addr;
      assign bwd_a[k]  = bif.bus_wdata;
      assign rd0_a[k]  = bif.m0_rdata;
      assign rd1_a[k]  = bif.m1_rdata;
      assign gnt_a[k]  = bif.gnt;
   end

   function automatic int ws_of(input int s);
      return (s == 0) ? 1 : (s == 1) ? 0 : 15;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (sel=%0d t=%0t)", nm, act, exp, sel, $time);
      end
   endtask

   // Monitor: invariants every cycle, strobe checked against the queue head, ack pops it.
   int   cyc = 0, last_ack = 0, run = 0;
   logic prev_s = 1'b0, s = 1'b0;
   initial forever begin
      exp_t e;
      @(negedge clk);
      cyc++;
      if (!rst_d) begin
         chk("rst_ctrl", {rd_a[sel], wr_a[sel], oe_a[sel], busy_a[sel],
                          ack0_a[sel], ack1_a[sel], gnt_a[sel]}, 0);
         chk("rst_data", {rd0_a[sel], rd1_a[sel], addr_a[sel], bwd_a[sel]}, 0);
         run    = 0;
         prev_s = 1'b0;
      end else begin
         s = rd_a[sel] | wr_a[sel];
         chk("rd_wr_excl", rd_a[sel] & wr_a[sel], 0);
         chk("ack_excl", ack0_a[sel] & ack1_a[sel], 0);
         chk("oe_eq_wr", oe_a[sel], wr_a[sel]);
         if (s) begin
            run = prev_s ? run + 1 : 1;
            if (exp_q.size() > 0) begin
               chk("strobe_addr", addr_a[sel], exp_q[0].addr);
               chk("strobe_dir", wr_a[sel], exp_q[0].wr);
               chk("strobe_gnt", gnt_a[sel], onehot2(exp_q[0].who));
               chk("strobe_busy", busy_a[sel], 1);
               if (exp_q[0].wr) chk("bus_wdata", bwd_a[sel], exp_q[0].wdata);
            end else begin
               chk("spurious_strobe", s, 0);
            end
         end
         if (ack0_a[sel] | ack1_a[sel]) begin
            if (exp_q.size() == 0) begin
               chk("spurious_ack", ack0_a[sel] | ack1_a[sel], 0);
            end else begin
               e = exp_q.pop_front();
               chk("ack_who", ack1_a[sel], e.who);
               chk("strobe_width", run, ws_of(sel) + 1);
               chk("ack_after_strobe", {prev_s, s}, 2'b10);
               chk("ack_gnt", gnt_a[sel], onehot2(e.who));
               chk("ack_busy", busy_a[sel], 1);
               chk("ack_addr", addr_a[sel], e.addr);
               chk("rdata", e.who ? rd1_a[sel] : rd0_a[sel], e.rdata);
               if (e.gap != 0) chk("ack_period", cyc - last_ack, e.gap);
               last_ack = cyc;
            end
         end
         prev_s = s;
      end
      if (done && !fin) begin
         chk("pending_exp", exp_q.size(), 0);
         fin = 1'b1;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic who, input logic wr, input logic [12:0] addr,
                       input logic [7:0] wdata, input int gap);
      exp_t e;
      e.who   = who;
      e.wr    = wr;
      e.addr  = addr;
      e.wdata = wdata;
      e.gap   = gap;
      if (!wr) rmod[sel][who] = bus_rdata;
      e.rdata = rmod[sel][who];
      exp_q.push_back(e);
   endtask

   // Hold each req until its n-th ack, bounded; missing acks surface as pending_exp.
   task automatic serve(input int n0, input int n1);
      int c0 = 0, c1 = 0, t = 0;
      m0_req = (n0 > 0);
      m1_req = (n1 > 0);
      while ((c0 < n0 || c1 < n1) && t < 200) begin
         @(negedge clk);
         t++;
         if (ack0_a[sel]) begin c0++; if (c0 >= n0) m0_req = 1'b0; end
         if (ack1_a[sel]) begin c1++; if (c1 >= n1) m1_req = 1'b0; end
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin rmod[i][0] = '0; rmod[i][1] = '0; end
      rst = 1'b0;
      idle(3);
      rst = 1'b1;
      idle(2);

      // WAIT_STATES=1: single read, single write
      sel = 0;
      m0_wr = 1'b0; m0_addr = 13'h0A5; bus_rdata = 8'h3C;
      push(1'b0, 1'b0, 13'h0A5, 8'h00, 0);
      serve(1, 0); idle(2);
      m1_wr = 1'b1; m1_addr = 13'h1FFF; m1_wdata = 8'hE7; bus_rdata = 8'h11;
      push(1'b1, 1'b1, 13'h1FFF, 8'hE7, 0);
      serve(0, 1); idle(2);

      // both held: m0, m1, m0, m1 every 4 cycles
      m0_addr = 13'h0100; bus_rdata = 8'h5A; m1_addr = 13'h0200; m1_wdata = 8'hC3;
      push(1'b0, 1'b0, 13'h0100, 8'h00, 0);
      push(1'b1, 1'b1, 13'h0200, 8'hC3, 4);
      push(1'b0, 1'b0, 13'h0100, 8'h00, 4);
      push(1'b1, 1'b1, 13'h0200, 8'hC3, 4);
      serve(2, 2); idle(2);

      // lock on two m0 transfers while m1 waits
      m0_addr = 13'h0AAA; bus_rdata = 8'h66; m1_addr = 13'h0BBB; m1_wdata = 8'h24;
`ifdef MEM_ARB_LOCK_EN
      m0_lock = 1'b1;
      push(1'b0, 1'b0, 13'h0AAA, 8'h00, 0);
      push(1'b0, 1'b0, 13'h0AAA, 8'h00, 4);
      push(1'b1, 1'b1, 13'h0BBB, 8'h24, 4);
`else
      push(1'b0, 1'b0, 13'h0AAA, 8'h00, 0);
      push(1'b1, 1'b1, 13'h0BBB, 8'h24, 4);
      push(1'b0, 1'b0, 13'h0AAA, 8'h00, 4);
`endif
      serve(2, 1);
`ifdef MEM_ARB_LOCK_EN
      m0_lock = 1'b0;
`endif
      idle(2);

      // reset in the second ACCESS cycle of an m0 read, then restart with req held
      for (int i = 0; i < 3; i++) begin rmod[i][0] = '0; rmod[i][1] = '0; end
      m0_addr = 13'h0123; bus_rdata = 8'h9E;
      push(1'b0, 1'b0, 13'h0123, 8'h00, 0);
      m0_req = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(1);
      rst = 1'b1;
      serve(1, 0); idle(2);

      // WAIT_STATES=0
      sel = 1;
      m0_wr = 1'b1; m0_addr = 13'h0042; m0_wdata = 8'h99;
      push(1'b0, 1'b1, 13'h0042, 8'h99, 0);
      serve(1, 0); idle(2);
      m1_wr = 1'b0; m1_addr = 13'h1001; bus_rdata = 8'hA1;
      push(1'b1, 1'b0, 13'h1001, 8'h00, 0);
      serve(0, 1); idle(2);
      bus_rdata = 8'h0F;
      push(1'b0, 1'b1, 13'h0042, 8'h99, 0);
      push(1'b1, 1'b0, 13'h1001, 8'h00, 3);
      serve(1, 1); idle(2);

      // WAIT_STATES=15
      sel = 2;
      m0_wr = 1'b0; m0_addr = 13'h1234; bus_rdata = 8'h77;
      push(1'b0, 1'b0, 13'h1234, 8'h00, 0);
      serve(1, 0); idle(2);
      m1_wr = 1'b1; m1_addr = 13'h0FFE; m1_wdata = 8'h5D;
      push(1'b1, 1'b1, 13'h0FFE, 8'h5D, 0);
      serve(0, 1); idle(2);
      bus_rdata = 8'hB4;
      push(1'b0, 1'b0, 13'h1234, 8'h00, 0);
      push(1'b1, 1'b1, 13'h0FFE, 8'h5D, 18);
      serve(1, 1); idle(3);

      done = 1'b1;
      idle(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
